// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a 2-flop input synchroniser, framing and
// parity checks, and a first-word-fall-through FIFO with a ready/valid read
// port. Errors are reported as one-cycle pulses; parity flags travel with data.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              uart_in,
  input  logic                              ready_in,
  output logic [BITS_N-1:0]                 data_rx,
  output logic                              valid_out,
  output logic                              parity_error,
  output logic                              frame_error,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_B  = BIT_W'(BITS_N - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic [1:0]        sync_q;
  logic              rx;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bitn_q, bitn_d;
  logic [BITS_N-1:0] shift_q, shift_d;
  logic              perr_q, perr_d;
  logic              push, ferr_d;
  logic              ferr_q, ovf_q, ovf_d;

  logic [BITS_N:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     count_q, count_d;
  logic              pop, full, push_ok;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], uart_in};
  end
  assign rx = sync_q[1];

  // Frame FSM: mid-bit sampling timed from the first synchronised low cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: if (!rx) begin
        state_d = S_START;
        cnt_d   = '0;
        bitn_d  = '0;
        perr_d  = 1'b0;
      end
      S_START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        state_d = rx ? S_IDLE : S_DATA;   // high at mid-start is a glitch
      end else cnt_d = cnt_q + CNT_W'(1);
      S_DATA: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        shift_d = {rx, shift_q[BITS_N-1:1]};
        if (bitn_q == LAST_B) state_d = (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
        else                  bitn_d  = bitn_q + BIT_W'(1);
      end else cnt_d = cnt_q + CNT_W'(1);
      S_PARITY: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        perr_d  = (PARITY_TYPE == 1) ? ~(^shift_q ^ rx) : (^shift_q ^ rx);
        state_d = S_STOP;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_STOP: if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        if (rx) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_WAIT;               // a held break reports only once
        end
      end else cnt_d = cnt_q + CNT_W'(1);
      S_WAIT: if (rx) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state registers; reset mid-frame discards the partial byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop     = (count_q != '0) && ready_in;
    full    = (count_q == DEPTH_C);
    push_ok = push && (!full || pop);
    ovf_d   = push && full && !pop;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage: parity flag kept alongside each byte.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= {(PARITY_TYPE != 0) && perr_q, shift_q};
  end

  assign valid_out    = (count_q != '0);
  assign data_rx      = valid_out ? mem_q[rd_q][BITS_N-1:0] : '0;
  assign parity_error = valid_out && mem_q[rd_q][BITS_N];
  assign frame_error  = ferr_q;
  assign overflow     = ovf_q;
  assign fifo_count   = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: u0 runs without parity, u1 with even parity, both
// with a 4-entry FIFO and 16 clocks per bit. A queue-level model predicts
// each instance's outputs from frame timing; literal checks pin key values.
module tb_uart_rx_fifo;
  localparam int C = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] line = 2'b11;
  logic [1:0] rdy = 2'b00;
  logic [7:0] dr [2];
  logic [1:0] vo, pe, fe, ov;
  logic [2:0] fc [2];

  int errors = 0, checks = 0, cyc = 0;
  int fe_cnt0 = 0, ov_cnt0 = 0;

  typedef struct { int inst; int at; int kind; logic [8:0] v; } ev_t;
  ev_t evq [$];

  logic [8:0] mq [2][D];
  int   mh [2], mc [2];
  logic fe_exp [2], ov_exp [2];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .BITS_N(8), .PARITY_TYPE(0), .FIFO_DEPTH(D)) u0 (
    .clk(clk), .rst(rst), .uart_in(line[0]), .ready_in(rdy[0]),
    .data_rx(dr[0]), .valid_out(vo[0]), .parity_error(pe[0]),
    .frame_error(fe[0]), .overflow(ov[0]), .fifo_count(fc[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(C), .BITS_N(8), .PARITY_TYPE(2), .FIFO_DEPTH(D)) u1 (
    .clk(clk), .rst(rst), .uart_in(line[1]), .ready_in(rdy[1]),
    .data_rx(dr[1]), .valid_out(vo[1]), .parity_error(pe[1]),
    .frame_error(fe[1]), .overflow(ov[1]), .fifo_count(fc[1]));

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] at cycle %0d: got %0h, expected %0h", nm, inst, cyc, act, exp);
    end
  endtask

  // Even parity mismatch flag; instance 0 has parity disabled.
  function automatic logic perr_of(input int inst, input logic [7:0] d, input logic pb);
    if (inst == 0) return 1'b0;
    return (^d) ^ pb;
  endfunction

  // Drive one frame starting at the current negedge. Line is sampled 2 cycles
  // later by the synchroniser, the FSM sees it one cycle after that, so the
  // stop sample lands at n + 3 + C/2 + (9 + P) * C.
  task automatic send(input int inst, input logic [7:0] d, input logic pb, input logic sb);
    int   p;
    ev_t  e;
    p = (inst == 1) ? 1 : 0;
    e.inst = inst;
    e.at   = cyc + 3 + C/2 + (9 + p) * C;
    e.kind = sb ? 0 : 1;
    e.v    = {perr_of(inst, d, pb), d};
    evq.push_back(e);
    line[inst] = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      line[inst] = d[k];
      repeat (C) @(negedge clk);
    end
    if (p == 1) begin
      line[inst] = pb;
      repeat (C) @(negedge clk);
    end
    line[inst] = sb;
    repeat (C) @(negedge clk);
  endtask

  task automatic pop1(input int inst);
    rdy[inst] = 1'b1;
    @(negedge clk);
    rdy[inst] = 1'b0;
  endtask

  // Model: FIFO of bytes with pop-before-push on each edge; events from send.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mh[i] = 0; mc[i] = 0; fe_exp[i] = 1'b0; ov_exp[i] = 1'b0;
      end
      evq.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        fe_exp[i] = 1'b0;
        ov_exp[i] = 1'b0;
        if (mc[i] > 0 && rdy[i]) begin
          mh[i] = (mh[i] + 1) % D;
          mc[i]--;
        end
      end
      for (int j = 0; j < evq.size(); ) begin
        if (evq[j].at == cyc) begin
          int i;
          i = evq[j].inst;
          if (evq[j].kind == 1) fe_exp[i] = 1'b1;
          else if (mc[i] < D) begin
            mq[i][(mh[i] + mc[i]) % D] = evq[j].v;
            mc[i]++;
          end else ov_exp[i] = 1'b1;
          evq.delete(j);
        end else j++;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (fe[0]) fe_cnt0++;
    if (ov[0]) ov_cnt0++;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        chk("rst_valid", i, vo[i], 0);
        chk("rst_data",  i, dr[i], 0);
        chk("rst_count", i, fc[i], 0);
        chk("rst_pulses", i, {pe[i], fe[i], ov[i]}, 0);
      end else begin
        chk("valid", i, vo[i], mc[i] > 0);
        chk("data",  i, dr[i], (mc[i] > 0) ? mq[i][mh[i]][7:0] : 8'h00);
        chk("perr",  i, pe[i], (mc[i] > 0) ? mq[i][mh[i]][8] : 1'b0);
        chk("count", i, fc[i], mc[i]);
        chk("frame_error", i, fe[i], fe_exp[i]);
        chk("overflow", i, ov[i], ov_exp[i]);
      end
    end
  end

  initial begin
    int base, s;
    repeat (3) @(negedge clk);
    chk("reset_valid", 0, vo[0], 0);
    chk("reset_count", 1, fc[1], 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte, no parity, then one-cycle pop.
    send(0, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t1_valid", 0, vo[0], 1);
    chk("t1_data",  0, dr[0], 8'hA5);
    chk("t1_perr",  0, pe[0], 0);
    chk("t1_count", 0, fc[0], 1);
    pop1(0);
    chk("t1_count_after_pop", 0, fc[0], 0);
    chk("t1_data_after_pop",  0, dr[0], 0);
    chk("t1_valid_after_pop", 0, vo[0], 0);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right.
    send(1, 8'h03, 1'b1, 1'b1);
    send(1, 8'h03, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2_data",  1, dr[1], 8'h03);
    chk("t2_perr1", 1, pe[1], 1);
    chk("t2_count", 1, fc[1], 2);
    pop1(1);
    chk("t2_perr2", 1, pe[1], 0);
    pop1(1);

    // Short low glitch is rejected silently.
    line[0] = 1'b0;
    repeat (5) @(negedge clk);
    line[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_glitch_count", 0, fc[0], 0);
    send(0, 8'h3C, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t3_data", 0, dr[0], 8'h3C);
    pop1(0);

    // Break: bad stop bit then line held low; one frame_error only.
    base = fe_cnt0;
    send(0, 8'h55, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    line[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_fe_pulses", 0, fe_cnt0 - base, 1);
    chk("t4_count", 0, fc[0], 0);
    send(0, 8'h11, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_data", 0, dr[0], 8'h11);
    pop1(0);

    // Overflow: five back-to-back frames into a 4-deep FIFO.
    base = ov_cnt0;
    for (int k = 1; k <= 5; k++) send(0, 8'(k), 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_count", 0, fc[0], 4);
    chk("t5_ovf_pulses", 0, ov_cnt0 - base, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("t5_drain", 0, dr[0], k);
      pop1(0);
    end
    chk("t5_empty", 0, fc[0], 0);

    // Refill, then pop exactly on the push cycle of a fifth frame.
    for (int k = 0; k < 4; k++) send(0, 8'h21 + 8'(k), 1'b0, 1'b1);
    s = cyc + 3 + C/2 + 9 * C;
    fork
      send(0, 8'h99, 1'b0, 1'b1);
      begin
        while (cyc < s - 1) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("t5_full_count", 0, fc[0], 4);
    chk("t5_no_new_ovf", 0, ov_cnt0 - base, 1);
    chk("t5_head", 0, dr[0], 8'h22);
    rdy[0] = 1'b1;
    repeat (4) @(negedge clk);
    rdy[0] = 1'b0;
    chk("t5_final_empty", 0, fc[0], 0);

    // Reset during bit 3, with entries held in both FIFOs.
    send(0, 8'h42, 1'b0, 1'b1);
    send(1, 8'h03, 1'b1, 1'b1);
    line[0] = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      line[0] = 1'b0;
      repeat (C) @(negedge clk);
    end
    line[0] = 1'b1;
    repeat (C/2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", 0, vo[0], 0);
    chk("t6_count", 0, fc[0], 0);
    chk("t6_data",  0, dr[0], 0);
    chk("t6_perr",  1, pe[1], 0);
    chk("t6_count", 1, fc[1], 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 8'h7E, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_data_after", 0, dr[0], 8'h7E);
    chk("t6_count_after", 0, fc[0], 1);
    pop1(0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receiver for the FPGA-to-NANO link: deserialises frames arriving from the NANO on the RX GPIO pin, checks framing and parity, and queues received bytes in a small first-word-fall-through FIFO with a ready/valid read port. It is the receive-direction counterpart to the button-triggered transmit path. Downstream command logic drains it at its own pace without losing back-to-back bytes.

## Interface
- CLKS_PER_BIT, 434 (50 MHz / 115200), clock cycles per UART bit, must be ≥ 4
- BITS_N, 8, data bits per frame, LSB first
- PARITY_TYPE, 0, 0 = none, 1 = odd, 2 = even
- FIFO_DEPTH, 16, entries; must be a power of 2, ≥ 2
- clk  input  1  system clock (CLOCK2_50)
- rst  input  1  reset, asynchronous, active-low
- uart_in  input  1  serial line from NANO, idle high, asynchronous to clk
- ready_in  input  1  consumer accepts head entry this cycle
- data_rx  output  BITS_N  head-of-FIFO data; 0 when FIFO empty
- valid_out  output  1  FIFO non-empty
- parity_error  output  1  parity flag stored with head entry; 0 when empty or PARITY_TYPE = 0
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- overflow  output  1  one-cycle pulse: good frame dropped, FIFO full
- fifo_count  output  $clog2(FIFO_DEPTH+1)  entries held

## Operation
- uart_in passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised signal.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on synchronised low, clear bit counter, go START.
- START: after CLKS_PER_BIT/2 cycles resample; low -> DATA, high -> IDLE (glitch rejected, nothing reported).
- DATA: every CLKS_PER_BIT cycles sample one bit into shift register, LSB first; after BITS_N bits -> PARITY if PARITY_TYPE ≠ 0, else STOP.
- PARITY: after CLKS_PER_BIT sample parity bit; mismatch vs. odd/even parity of data sets entry parity flag.
- STOP: after CLKS_PER_BIT sample stop bit. High: push {flag, data} and go IDLE. Low: discard byte, pulse frame_error, go WAIT_IDLE.
- WAIT_IDLE: stay until line synchronised high, then IDLE (a held break reports one frame_error only).
- Push when FIFO not full, or full with a pop in the same cycle (count unchanged, both succeed). Otherwise drop, pulse overflow; FIFO contents untouched.
- Pop when valid_out && ready_in. ready_in ignored when empty.
- Pointers wrap modulo FIFO_DEPTH; fifo_count = pushes − pops, never exceeds FIFO_DEPTH.
- Bytes leave in arrival order. Parity-errored bytes are queued, not dropped.

## Timing
- Reset (rst low): FSM IDLE, pointers/count 0, valid_out 0, data_rx 0, parity_error 0, frame_error 0, overflow 0, synchroniser 1. Takes effect immediately, mid-frame included; partial frame discarded.
- Mid-bit sample points relative to first cycle synchronised line is low (t0): start at t0 + CLKS_PER_BIT/2; data bit k at + (k+1)·CLKS_PER_BIT; parity at + (BITS_N+1)·CLKS_PER_BIT; stop at + (BITS_N+1+P)·CLKS_PER_BIT, P = 1 if parity enabled.
- Push on stop-sample cycle; valid_out, data_rx, fifo_count update next cycle.
- Pop: on cycle where valid_out && ready_in, next head (or empty state) visible next cycle. Sustained one pop per cycle.
- frame_error and overflow assert the cycle after stop sample, for exactly one cycle.
- Back-to-back frames (stop bit immediately followed by start bit) received without loss.

## Test plan
- CLKS_PER_BIT = 16, no parity, send 0xA5, ready_in = 0 -> valid_out = 1, data_rx = 0xA5, parity_error = 0, fifo_count = 1; pulse ready_in one cycle -> fifo_count = 0, data_rx = 0, valid_out = 0.
- PARITY_TYPE = 2, send 0x03 with parity bit 1 -> data_rx = 0x03, parity_error = 1; repeat with parity bit 0 -> second entry parity_error = 0.
- Line low 5 cycles then high -> no push, no frame_error, FSM back in IDLE; subsequent 0x3C received correctly.
- Send 0x55 with stop bit 0, hold line low 100 cycles -> exactly one frame_error pulse, fifo_count unchanged; after line high, 0x11 received correctly.
- FIFO_DEPTH = 4, send 0x01..0x05 back-to-back with ready_in = 0 -> fifo_count = 4, one overflow pulse on 5th frame, drain yields 0x01..0x04 in order; refill to 4, assert ready_in on push cycle of next frame -> no overflow, fifo_count stays 4.
- Assert rst during bit 3 of a frame -> all outputs at reset values immediately; after release, next full frame 0x7E received correctly.
